// File: rtl/pacman_video_pkg.sv
// Shared constants and types for the Pacman VGA colour path.
// Game-state encodings, reserved colour codes and the per-pixel pipeline tag.
// No logic; imported by sprite_hit_unit and sprite_compositor.
package pacman_video_pkg;

    localparam logic [3:0] ST_START = 4'd1;
    localparam logic [3:0] ST_PLAY  = 4'd2;
    localparam logic [3:0] ST_LOSE  = 4'd4;
    localparam logic [3:0] ST_WIN   = 4'd7;

    localparam logic [2:0] TRANSPARENT  = 3'b000;
    localparam logic [2:0] COIN_COLOR   = 3'b010;
    localparam logic [2:0] FRIGHT_COLOR = 3'b001;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int BGA_W  = 15;

    // Per-pixel attributes that ride alongside the ROM reads.
    typedef struct packed {
        logic [3:0] state;
        logic       frame_start;
        logic       coin_present;
    } tag_t;

    // States that show a full-screen image instead of the maze.
    function automatic logic is_screen_state(input logic [3:0] s);
        return (s == ST_START) || (s == ST_LOSE) || (s == ST_WIN);
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite hit test and sprite-ROM address for one pixel, registered.
// Latency 1 cycle (hit_o/addr_o valid the cycle after load_i); no backpressure.
// Ports: clock_i/rst_i, load_i with pixel x_i/y_i, sprite origin sx_i/sy_i, en_i; hit_o, addr_o.
module sprite_hit_unit
    import pacman_video_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int ADDR_W   = 6
) (
    input  logic              clock_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    input  logic [X_W-1:0]    sx_i,
    input  logic [Y_W-1:0]    sy_i,
    input  logic              en_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [X_W:0]      x_end;
    logic [Y_W:0]      y_end;
    logic [X_W-1:0]    dx;
    logic [Y_W-1:0]    dy;
    logic [15:0]       addr_full;
    logic              hit_d, hit_q;
    logic [ADDR_W-1:0] addr_d, addr_q;

    // One extra bit on the far edge so a sprite hanging off the right or
    // bottom of the screen clips instead of wrapping back onto column/row 0.
    assign x_end = {1'b0, sx_i} + (X_W+1)'(SPRITE_W);
    assign y_end = {1'b0, sy_i} + (Y_W+1)'(SPRITE_H);

    assign hit_d = en_i && (x_i >= sx_i) && ({1'b0, x_i} < x_end)
                        && (y_i >= sy_i) && ({1'b0, y_i} < y_end);

    // Offsets are only meaningful on a hit; the address is don't-care otherwise.
    assign dx        = x_i - sx_i;
    assign dy        = y_i - sy_i;
    assign addr_full = 16'(dy) * 16'(SPRITE_W) + 16'(dx);
    assign addr_d    = addr_full[ADDR_W-1:0];

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else if (load_i) begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign hit_o  = hit_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel layer compositor: screens, maze, coins, sprites; blink and collision report.
// Latency ROM_LAT+2 cycles pixel_valid_i -> color_valid_o, 1 pixel/cycle; no backpressure, gaps pass through.
// Ports: pixel stream + sprite table in, ROM addresses out, ROM data in, colour/collision out.
module sprite_compositor
    import pacman_video_pkg::*;
#(
    parameter int NUM_SPRITES  = 4,
    parameter int SPRITE_W     = 8,
    parameter int SPRITE_H     = 8,
    parameter int SCREEN_W     = 160,
    parameter int COLOR_W      = 3,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 16,
    localparam int SA_W        = $clog2(SPRITE_W*SPRITE_H)
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          pixel_valid_i,
    input  logic [X_W-1:0]                x_i,
    input  logic [Y_W-1:0]                y_i,
    input  logic                          frame_start_i,
    input  logic [3:0]                    state_i,
    input  logic                          coin_present_i,
    input  logic                          frightened_i,
    input  logic [X_W*NUM_SPRITES-1:0]    sprite_x_i,
    input  logic [Y_W*NUM_SPRITES-1:0]    sprite_y_i,
    input  logic [NUM_SPRITES-1:0]        sprite_en_i,
    output logic [BGA_W-1:0]              bg_addr_o,
    output logic [SA_W*NUM_SPRITES-1:0]   sprite_addr_o,
    input  logic [COLOR_W-1:0]            bg_color_i,
    input  logic [COLOR_W-1:0]            coin_color_i,
    input  logic [COLOR_W-1:0]            screen_color_i,
    input  logic [COLOR_W*NUM_SPRITES-1:0] sprite_color_i,
    output logic [COLOR_W-1:0]            color_o,
    output logic                          color_valid_o,
    output logic                          collide_o,
    output logic [NUM_SPRITES-2:0]        collide_mask_o
);

    localparam int BC_W = $clog2(BLINK_FRAMES+1);
    localparam logic [COLOR_W-1:0] TRANSP_C = COLOR_W'(TRANSPARENT);
    localparam logic [COLOR_W-1:0] COIN_C   = COLOR_W'(COIN_COLOR);
    localparam logic [COLOR_W-1:0] FRIGHT_C = COLOR_W'(FRIGHT_COLOR);

    // ---------------- Stage A: tags, background address, sprite hits ----------
    logic                   va_q;
    tag_t                   tag_a_d, tag_a_q;
    logic [BGA_W-1:0]       bg_addr_d, bg_addr_q;
    logic [NUM_SPRITES-1:0] hit_a;

    assign tag_a_d   = '{state: state_i, frame_start: frame_start_i, coin_present: coin_present_i};
    assign bg_addr_d = BGA_W'(32'(y_i) * SCREEN_W + 32'(x_i));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            va_q      <= 1'b0;
            tag_a_q   <= '0;
            bg_addr_q <= '0;
        end else begin
            va_q <= pixel_valid_i;
            if (pixel_valid_i) begin
                tag_a_q   <= tag_a_d;
                bg_addr_q <= bg_addr_d;
            end
        end
    end

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
        sprite_hit_unit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (SA_W)
        ) u_hit (
            .clock_i (clock_i),
            .rst_i   (reset_i),
            .load_i  (pixel_valid_i),
            .x_i     (x_i),
            .y_i     (y_i),
            .sx_i    (sprite_x_i[k*X_W +: X_W]),
            .sy_i    (sprite_y_i[k*Y_W +: Y_W]),
            .en_i    (sprite_en_i[k]),
            .hit_o   (hit_a[k]),
            .addr_o  (sprite_addr_o[k*SA_W +: SA_W])
        );
    end

    assign bg_addr_o = bg_addr_q;

    // ---------------- Delay line: match ROM read latency ----------------------
    logic                   dl_vld_q [ROM_LAT];
    tag_t                   dl_tag_q [ROM_LAT];
    logic [NUM_SPRITES-1:0] dl_hit_q [ROM_LAT];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_vld_q[i] <= 1'b0;
                dl_tag_q[i] <= '0;
                dl_hit_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0] <= va_q;
            dl_tag_q[0] <= tag_a_q;
            dl_hit_q[0] <= hit_a;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_tag_q[i] <= dl_tag_q[i-1];
                dl_hit_q[i] <= dl_hit_q[i-1];
            end
        end
    end

    logic                   f_vld;
    tag_t                   f_tag;
    logic [NUM_SPRITES-1:0] f_hit;

    assign f_vld = dl_vld_q[ROM_LAT-1];
    assign f_tag = dl_tag_q[ROM_LAT-1];
    assign f_hit = dl_hit_q[ROM_LAT-1];

    // ---------------- Blink phase ---------------------------------------------
    // The counter holds how many frames of the current half-period have begun,
    // so the frame_start pixel itself already sees the phase of its new frame.
    logic [BC_W-1:0] blink_cnt_d, blink_cnt_q;
    logic            phase_d, phase_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!frightened_i) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (f_vld && f_tag.frame_start) begin
            if (blink_cnt_q == BC_W'(BLINK_FRAMES)) begin
                blink_cnt_d = BC_W'(1);
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BC_W'(1);
            end
        end
    end

    // ---------------- Composite -----------------------------------------------
    logic [COLOR_W-1:0]     spr_c [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] opaque;
    logic                   ghost_vld;
    logic [COLOR_W-1:0]     ghost_c;
    logic                   coin_hit;
    logic [NUM_SPRITES-2:0] coll_now;
    logic [COLOR_W-1:0]     pix_c;

    always_comb begin
        opaque    = '0;
        ghost_vld = 1'b0;
        ghost_c   = '0;
        coll_now  = '0;
        pix_c     = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            spr_c[k]  = sprite_color_i[k*COLOR_W +: COLOR_W];
            opaque[k] = f_hit[k] && (spr_c[k] != TRANSP_C);
        end
        // Walk downwards so the lowest-index opaque ghost is the one left selected.
        for (int k = NUM_SPRITES-1; k >= 1; k--) begin
            if (opaque[k]) begin
                ghost_vld = 1'b1;
                ghost_c   = spr_c[k];
            end
        end
        if (frightened_i && !phase_d) begin
            ghost_c = FRIGHT_C;
        end
        coin_hit = f_tag.coin_present && (coin_color_i == COIN_C);

        if (is_screen_state(f_tag.state)) begin
            pix_c = screen_color_i;
        end else if (f_tag.state == ST_PLAY) begin
            if (opaque[0])      pix_c = spr_c[0];
            else if (coin_hit)  pix_c = COIN_C;
            else if (ghost_vld) pix_c = ghost_c;
            else                pix_c = bg_color_i;
            for (int k = 1; k < NUM_SPRITES; k++) begin
                coll_now[k-1] = opaque[0] && opaque[k];
            end
        end
    end

    // ---------------- Collision bookkeeping -----------------------------------
    logic [NUM_SPRITES-2:0] sticky_d, sticky_q;
    logic [NUM_SPRITES-2:0] mask_d, mask_q;
    logic                   collide_d, collide_q;
    logic [COLOR_W-1:0]     color_d, color_q;
    logic                   valid_q;

    always_comb begin
        sticky_d  = sticky_q;
        mask_d    = mask_q;
        collide_d = 1'b0;
        color_d   = color_q;
        if (f_vld) begin
            color_d = pix_c;
            if (f_tag.frame_start) begin
                // Report the finished frame; this pixel starts the new one.
                collide_d = |sticky_q;
                mask_d    = sticky_q;
                sticky_d  = coll_now;
            end else begin
                sticky_d  = sticky_q | coll_now;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            color_q     <= '0;
            valid_q     <= 1'b0;
            collide_q   <= 1'b0;
            mask_q      <= '0;
            sticky_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            color_q     <= color_d;
            valid_q     <= f_vld;
            collide_q   <= collide_d;
            mask_q      <= mask_d;
            sticky_q    <= sticky_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign color_o        = color_q;
    assign color_valid_o  = valid_q;
    assign collide_o      = collide_q;
    assign collide_mask_o = mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus random pixels vs. a reference model.
// ROMs are modelled as synchronous 1-cycle memories filled with random content.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_sprite_compositor;
    import pacman_video_pkg::*;

    localparam int NS = 4, SW = 8, SH = 8, SCW = 160, CW = 3, RL = 1, BF = 2;
    localparam int AW = 6, L = RL + 2;

    logic            clock_i = 1'b0, reset_i = 1'b1, pixel_valid_i = 1'b0;
    logic [7:0]      x_i = '0;
    logic [6:0]      y_i = '0;
    logic            frame_start_i = 1'b0, coin_present_i = 1'b0, frightened_i = 1'b0;
    logic [3:0]      state_i = '0;
    logic [8*NS-1:0] sprite_x_i = '0;
    logic [7*NS-1:0] sprite_y_i = '0;
    logic [NS-1:0]   sprite_en_i = '0;
    logic [14:0]     bg_addr_o;
    logic [AW*NS-1:0] sprite_addr_o;
    logic [CW-1:0]   bg_color_i = '0, coin_color_i = '0, screen_color_i = '0;
    logic [CW*NS-1:0] sprite_color_i = '0;
    logic [CW-1:0]   color_o;
    logic            color_valid_o, collide_o;
    logic [NS-2:0]   collide_mask_o;

    sprite_compositor #(
        .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(SCW),
        .COLOR_W(CW), .ROM_LAT(RL), .BLINK_FRAMES(BF)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .pixel_valid_i(pixel_valid_i),
        .x_i(x_i), .y_i(y_i), .frame_start_i(frame_start_i), .state_i(state_i),
        .coin_present_i(coin_present_i), .frightened_i(frightened_i),
        .sprite_x_i(sprite_x_i), .sprite_y_i(sprite_y_i), .sprite_en_i(sprite_en_i),
        .bg_addr_o(bg_addr_o), .sprite_addr_o(sprite_addr_o),
        .bg_color_i(bg_color_i), .coin_color_i(coin_color_i), .screen_color_i(screen_color_i),
        .sprite_color_i(sprite_color_i), .color_o(color_o), .color_valid_o(color_valid_o),
        .collide_o(collide_o), .collide_mask_o(collide_mask_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // ---------------- ROM models ----------------
    logic [2:0] bg_mem [32768];
    logic [2:0] coin_mem [32768];
    logic [2:0] scr_mem [32768];
    logic [2:0] spr_mem [NS][64];

    always @(posedge clock_i) begin
        bg_color_i     <= bg_mem[bg_addr_o];
        coin_color_i   <= coin_mem[bg_addr_o];
        screen_color_i <= scr_mem[bg_addr_o];
        for (int k = 0; k < NS; k++)
            sprite_color_i[k*CW +: CW] <= spr_mem[k][sprite_addr_o[k*AW +: AW]];
    end

    // ---------------- Checking ----------------
    int n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct {
        logic [2:0] col;
        logic       cl;
        logic [2:0] msk;
        int         issue;
    } exp_t;

    exp_t       exp_q[$];
    int         sx_t[NS], sy_t[NS];
    logic       en_t[NS];
    int         fcount = 0;          // frame_starts seen since frightened went high
    logic [2:0] sticky_m = '0, mask_m = '0;

    task automatic apply_sprites();
        for (int k = 0; k < NS; k++) begin
            sprite_x_i[k*8 +: 8] = 8'(sx_t[k]);
            sprite_y_i[k*7 +: 7] = 7'(sy_t[k]);
            sprite_en_i[k]       = en_t[k];
        end
    endtask

    task automatic model_pixel(input int px, input int py, input logic fs,
                               input logic [3:0] st, input logic cp, output exp_t e);
        int         bga, phase;
        logic [2:0] c[NS];
        logic       op[NS];
        logic [2:0] colls;
        logic       hit, gsel;
        logic [2:0] gcol;
        bga = SCW * py + px;
        for (int k = 0; k < NS; k++) begin
            hit = en_t[k] && px >= sx_t[k] && px < sx_t[k] + SW && py >= sy_t[k] && py < sy_t[k] + SH;
            c[k]  = hit ? spr_mem[k][(py - sy_t[k]) * SW + (px - sx_t[k])] : 3'b000;
            op[k] = hit && c[k] != 3'b000;
        end
        if (frightened_i && fs) fcount++;
        phase = (fcount == 0) ? 0 : ((fcount - 1) / BF) % 2;
        colls = '0;
        if (st == 4'd2 && op[0])
            for (int k = 1; k < NS; k++) colls[k-1] = op[k];
        if (fs) begin
            e.cl = |sticky_m; mask_m = sticky_m; sticky_m = colls;
        end else begin
            e.cl = 1'b0; sticky_m = sticky_m | colls;
        end
        e.msk = mask_m;
        gsel = 1'b0; gcol = '0;
        for (int k = 1; k < NS; k++)
            if (op[k] && !gsel) begin gsel = 1'b1; gcol = c[k]; end
        if (gsel && frightened_i && phase == 0) gcol = 3'b001;
        case (st)
            4'd1, 4'd4, 4'd7: e.col = scr_mem[bga];
            4'd2: begin
                if (op[0])                           e.col = c[0];
                else if (coin_mem[bga] == 3'd2 && cp) e.col = 3'd2;
                else if (gsel)                       e.col = gcol;
                else                                 e.col = bg_mem[bga];
            end
            default: e.col = 3'b000;
        endcase
        e.issue = cyc;
    endtask

    // Leaves pixel_valid_i high; the next task call decides whether a gap follows.
    task automatic send(input int px, input int py, input logic fs, input logic [3:0] st, input logic cp);
        exp_t e;
        model_pixel(px, py, fs, st, cp, e);
        exp_q.push_back(e);
        x_i = 8'(px); y_i = 7'(py); frame_start_i = fs; state_i = st; coin_present_i = cp;
        pixel_valid_i = 1'b1;
        @(posedge clock_i); #1;
        frame_start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_valid_i = 1'b0;
        repeat (n) begin @(posedge clock_i); #1; end
    endtask

    task automatic wait_out(output logic [2:0] col, output logic cl, output logic [2:0] msk);
        logic got;
        got = 1'b0; col = '0; cl = 1'b0; msk = '0;
        pixel_valid_i = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock_i);
            if (color_valid_o) begin
                got = 1'b1; col = color_o; cl = collide_o; msk = collide_mask_o;
            end
        end
        if (!got) check_eq("out_timeout", 32'(color_valid_o), 32'd1);
        @(posedge clock_i); #1;
    endtask

    // ---------------- Output monitor ----------------
    logic [2:0] last_color = '0;

    always @(negedge clock_i) begin
        exp_t e;
        if (reset_i) begin
            last_color = '0;
        end else if (color_valid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(color_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("color", 32'(color_o), 32'(e.col));
                check_eq("collide", 32'(collide_o), 32'(e.cl));
                check_eq("mask", 32'(collide_mask_o), 32'(e.msk));
                check_eq("latency", cyc - e.issue, L);
            end
            last_color = color_o;
        end else begin
            check_eq("gap_hold", 32'(color_o), 32'(last_color));
            check_eq("gap_collide", 32'(collide_o), 32'd0);
        end
    end

    // ---------------- Stimulus ----------------
    logic [2:0] col, msk;
    logic       cl;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            bg_mem[i]   = 3'($urandom);
            coin_mem[i] = ($urandom_range(0, 2) == 0) ? 3'd2 : 3'($urandom);
            scr_mem[i]  = 3'($urandom);
        end
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < 64; a++)
                spr_mem[k][a] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
        for (int k = 0; k < NS; k++) begin sx_t[k] = 0; sy_t[k] = 0; en_t[k] = 1'b0; end
        apply_sprites();

        // Reset state
        repeat (3) @(posedge clock_i); #1;
        check_eq("rst_color", 32'(color_o), 32'd0);
        check_eq("rst_valid", 32'(color_valid_o), 32'd0);
        check_eq("rst_collide", 32'(collide_o), 32'd0);
        check_eq("rst_mask", 32'(collide_mask_o), 32'd0);
        reset_i = 1'b0;
        idle(2);

        // Start screen
        scr_mem[323] = 3'b101;
        send(3, 2, 1'b0, ST_START, 1'b0);
        check_eq("start_bg_addr", 32'(bg_addr_o), 32'd323);
        wait_out(col, cl, msk);
        check_eq("start_color", 32'(col), 32'h5);

        // Sprite 0 over ghost 1
        sx_t[0] = 10; sy_t[0] = 10; en_t[0] = 1'b1;
        sx_t[1] = 10; sy_t[1] = 10; en_t[1] = 1'b1;
        apply_sprites();
        spr_mem[0][10] = 3'b110; spr_mem[1][10] = 3'b101; coin_mem[SCW*11+12] = 3'd2;
        send(12, 11, 1'b0, ST_PLAY, 1'b0);
        check_eq("prio_addr0", 32'(sprite_addr_o[5:0]), 32'd10);
        wait_out(col, cl, msk);
        check_eq("prio_color", 32'(col), 32'h6);

        // Coin beats ghost; transparent sprite 0 does not cover the coin
        en_t[0] = 1'b0; apply_sprites();
        send(12, 11, 1'b0, ST_PLAY, 1'b1);
        wait_out(col, cl, msk);
        check_eq("coin_over_ghost", 32'(col), 32'h2);
        en_t[0] = 1'b1; spr_mem[0][10] = 3'b000; apply_sprites();
        send(12, 11, 1'b0, ST_PLAY, 1'b1);
        wait_out(col, cl, msk);
        check_eq("coin_transp_s0", 32'(col), 32'h2);
        send(12, 11, 1'b0, ST_PLAY, 1'b0);
        wait_out(col, cl, msk);
        check_eq("ghost_no_coin", 32'(col), 32'h5);

        // Right-edge clipping
        en_t[0] = 1'b0; en_t[1] = 1'b0;
        sx_t[3] = 156; sy_t[3] = 20; en_t[3] = 1'b1; apply_sprites();
        bg_mem[SCW*21] = 3'b011; spr_mem[3][8] = 3'b111; spr_mem[3][11] = 3'b100;
        coin_mem[SCW*21+159] = 3'd0;
        send(0, 21, 1'b0, ST_PLAY, 1'b0);
        wait_out(col, cl, msk);
        check_eq("clip_no_wrap", 32'(col), 32'h3);
        send(159, 21, 1'b0, ST_PLAY, 1'b0);
        check_eq("clip_addr3", 32'(sprite_addr_o[3*AW +: AW]), 32'd11);
        wait_out(col, cl, msk);
        check_eq("clip_hit", 32'(col), 32'h4);

        // Collision report: sprite 0 and ghost 2 overlap in frame 1
        en_t[3] = 1'b0;
        sx_t[0] = 30; sy_t[0] = 5; en_t[0] = 1'b1;
        sx_t[2] = 32; sy_t[2] = 6; en_t[2] = 1'b1; apply_sprites();
        spr_mem[0][19] = 3'b110; spr_mem[2][9] = 3'b011;
        send(0, 0, 1'b1, ST_PLAY, 1'b0); wait_out(col, cl, msk);
        send(33, 7, 1'b0, ST_PLAY, 1'b0); wait_out(col, cl, msk);
        send(0, 0, 1'b1, ST_PLAY, 1'b0); wait_out(col, cl, msk);
        check_eq("coll_pulse", 32'(cl), 32'd1);
        check_eq("coll_mask", 32'(msk), 32'h2);
        send(50, 50, 1'b0, ST_PLAY, 1'b0); wait_out(col, cl, msk);
        check_eq("coll_one_cycle", 32'(cl), 32'd0);
        check_eq("coll_mask_held", 32'(msk), 32'h2);
        send(0, 0, 1'b1, ST_PLAY, 1'b0); wait_out(col, cl, msk);
        check_eq("coll_none", 32'(cl), 32'd0);
        check_eq("coll_mask_clr", 32'(msk), 32'h0);

        // Frightened blinking, two frames per half-period
        for (int k = 0; k < NS; k++) en_t[k] = 1'b0;
        sx_t[1] = 60; sy_t[1] = 40; en_t[1] = 1'b1; apply_sprites();
        spr_mem[1][9] = 3'b101;
        frightened_i = 1'b1;
        idle(L + 2);
        for (int f = 0; f < 5; f++) begin
            send(0, 0, 1'b1, ST_PLAY, 1'b0); wait_out(col, cl, msk);
            send(61, 41, 1'b0, ST_PLAY, 1'b0); wait_out(col, cl, msk);
            check_eq($sformatf("blink_f%0d", f), 32'(col), ((f / 2) % 2 == 1) ? 32'h5 : 32'h1);
        end
        idle(L + 2);
        frightened_i = 1'b0; fcount = 0;

        // Reset mid-frame with a collision in flight
        en_t[1] = 1'b0; en_t[0] = 1'b1; en_t[2] = 1'b1;
        sx_t[0] = 30; sy_t[0] = 5; sx_t[2] = 32; sy_t[2] = 6; apply_sprites();
        send(0, 0, 1'b1, ST_PLAY, 1'b0);
        send(33, 7, 1'b0, ST_PLAY, 1'b0);
        send(33, 7, 1'b0, ST_PLAY, 1'b0);
        pixel_valid_i = 1'b0;
        reset_i = 1'b1;
        exp_q.delete(); sticky_m = '0; mask_m = '0; fcount = 0;
        @(posedge clock_i); #1;
        check_eq("mid_rst_color", 32'(color_o), 32'd0);
        check_eq("mid_rst_valid", 32'(color_valid_o), 32'd0);
        check_eq("mid_rst_collide", 32'(collide_o), 32'd0);
        check_eq("mid_rst_mask", 32'(collide_mask_o), 32'd0);
        reset_i = 1'b0;
        idle(2);
        send(0, 0, 1'b1, ST_PLAY, 1'b0); wait_out(col, cl, msk);
        check_eq("post_rst_no_coll", 32'(cl), 32'd0);

        // Random traffic
        for (int b = 0; b < 6; b++) begin
            idle(L + 2);
            frightened_i = 1'($urandom_range(0, 1));
            if (!frightened_i) fcount = 0;
            for (int p = 0; p < 500; p++) begin
                int px, py;
                logic fs;
                logic [3:0] st;
                if (p % 40 == 0) begin
                    for (int k = 0; k < NS; k++) begin
                        sx_t[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 159) : $urandom_range(0, 36);
                        sy_t[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 24);
                        en_t[k] = ($urandom_range(0, 4) != 0);
                    end
                    apply_sprites();
                end
                fs = ($urandom_range(0, 19) == 0);
                px = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 159) : $urandom_range(0, 44);
                py = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 32);
                if (fs) begin px = 0; py = 0; end
                case ($urandom_range(0, 9))
                    0: st = 4'd1;
                    1: st = 4'd4;
                    2: st = 4'd7;
                    3: st = 4'($urandom_range(8, 15));
                    default: st = 4'd2;
                endcase
                send(px, py, fs, st, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end

        // Drain, bounded
        pixel_valid_i = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock_i);
        check_eq("drain_empty", exp_q.size(), 0);
        @(posedge clock_i); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised per-pixel colour compositor for the VGA path of the Pacman design. It sits between the pixel scanner and the VGA adapter, and composites these layers into one colour per pixel:
- full-screen images (start, lose, win);
- background maze;
- coins;
- NUM_SPRITES sprites, with sprite 0 as Pacman and the rest as ghosts.

It issues addresses to external image/sprite ROMs and aligns their read latency with a valid-tagged pipeline. It also adds transparency, frightened-ghost blinking and a per-frame Pacman/ghost collision report.

## Interface
- NUM_SPRITES, 4, sprite count (≥2); index 0 = Pacman
- SPRITE_W, 8, sprite width in pixels (power of 2)
- SPRITE_H, 8, sprite height in pixels
- SCREEN_W, 160, visible columns
- COLOR_W, 3, colour width
- ROM_LAT, 1, read latency of every external ROM, in cycles (≥1)
- BLINK_FRAMES, 16, frames per frightened-blink half-period
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- pixel_valid  in  1  x/y/frame_start/state/coin_present are valid this cycle
- x  in  8  pixel column
- y  in  7  pixel row
- frame_start  in  1  set together with pixel (0,0)
- state  in  4  game state
- coin_present  in  1  coin for this pixel not yet eaten
- frightened  in  1  ghosts in frightened mode
- sprite_x  in  8*NUM_SPRITES  top-left column per sprite
- sprite_y  in  7*NUM_SPRITES  top-left row per sprite
- sprite_en  in  NUM_SPRITES  sprite drawn/considered
- bg_addr  out  15  160*y+x, to the background, coin and screen ROMs
- sprite_addr  out  clog2(SPRITE_W*SPRITE_H)*NUM_SPRITES  (y-sy)*SPRITE_W+(x-sx) per sprite
- bg_color, coin_color, screen_color  in  COLOR_W each  ROM data
- sprite_color  in  COLOR_W*NUM_SPRITES  sprite ROM data
- color  out  COLOR_W  composited pixel
- color_valid  out  1  color is valid
- collide  out  1  one-cycle pulse: collision occurred in the previous frame
- collide_mask  out  NUM_SPRITES-1  ghosts that collided in the previous frame; held until the next report

## Operation
- **Stage A.** On pixel_valid, register x, y, state, frame_start and coin_present.
  - Compute per-sprite hit: sprite_en[k] && x ≥ sx && x < sx+SPRITE_W && y ≥ sy && y < sy+SPRITE_H.
  - Do the compare in 9/8-bit widths so a sprite near the right/bottom edge clips and never wraps to column/row 0.
  - Register bg_addr and sprite_addr. sprite_addr is don't-care when there is no hit.
- **Delay line.** Delay the tags and hits by ROM_LAT so they align with the ROM data.
- **Final stage: composite and register color.**
  - ST_START, ST_LOSE, ST_WIN: screen_color.
  - ST_PLAY, first match wins:
    1. sprite 0 opaque;
    2. coin (coin_color==COIN_COLOR && coin_present);
    3. ghosts 1..N-1 opaque, lowest index first;
    4. bg_color.
  - Opaque means hit && sprite_color != TRANSPARENT.
  - Frightened ghosts: a chosen ghost pixel outputs FRIGHT_COLOR when frightened && blink phase = 0; otherwise it keeps its own colour.
  - Any other state value: 0.
- **Blink counter.** Counts delayed frame_starts while frightened. Phase toggles every BLINK_FRAMES frames. When frightened=0, counter and phase clear to 0.
- **Collision.** In ST_PLAY, sticky bit k sets when sprite 0 and ghost k are both opaque on the same pixel.
  - When the delayed frame_start reaches the final stage: pulse collide if any sticky bit is set, load collide_mask, clear the sticky bits. The current pixel then accumulates into the new frame.
- **Reset.** color=0, color_valid=0, collide=0, collide_mask=0, all pipeline valids=0, sticky bits=0, blink counter=0, phase=0. Reset mid-frame discards in-flight pixels; no collision is reported for the partial frame.

## Timing
- Latency L = ROM_LAT+2 cycles: pixel_valid in cycle n gives color_valid in cycle n+L. Throughput 1 pixel/cycle.
- bg_addr/sprite_addr are valid in cycle n+1; ROM data is sampled in cycle n+1+ROM_LAT.
- State is sampled per pixel at stage A. A state change mid-stream affects only pixels sampled after the change.
- pixel_valid gaps propagate as color_valid gaps; color holds its value during gaps.
- collide pulses in the same cycle as color_valid for pixel (0,0) of the new frame.

## Structure
- Package pacman_video_pkg:
  - ST_START=4'd1, ST_PLAY=4'd2, ST_LOSE=4'd4, ST_WIN=4'd7;
  - TRANSPARENT=3'b000, COIN_COLOR=3'b010, FRIGHT_COLOR=3'b001.
- Sub-module sprite_hit_unit: one instance per sprite (generate loop). Does the hit compare, clipping and address computation for one sprite, registered.

## Test plan
- **Start screen.** Reset, then state=1, pixel (3,2) valid at cycle 0 → bg_addr=323 at cycle 1; color=screen_color at cycle 3 with color_valid.
- **Sprite priority.** Play state, sprite 0 at (10,10) opaque 3'b110, ghost 1 at (10,10) opaque, pixel (12,11) → color=3'b110, sprite_addr0=10.
- **Priority and transparency.** Coin under ghost 1 (coin_color=2, coin_present=1) → color=2. Same pixel with sprite 0 colour 0 → still 2. Same with coin_present=0 → ghost colour.
- **Edge clipping.** Ghost at x=156, pixel x=0 on the same rows → no hit, color=bg_color. Pixel x=159 → hit, address offset 3.
- **Collision report.** Sprite 0 and ghost 2 overlap opaquely in frame 1 → at frame 2's (0,0) output: collide=1 for one cycle, collide_mask=3'b010. Frame 2 has no overlap → frame 3: collide=0, mask=3'b000.
- **Blink and reset.** frightened=1, BLINK_FRAMES=2: ghost pixels are FRIGHT_COLOR in frames 0-1, normal in frames 2-3, FRIGHT again in frame 4. Reset asserted mid-frame → all outputs 0 the next cycle and no collide pulse.
